// File: rtl/veerwolf_sw_debounce_if.sv
// veerwolf_sw_debounce_if: switch-side and SoC-side signals of the switch debouncer
interface veerwolf_sw_debounce_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] change;
  logic             irq;
  logic             irq_ack;
  modport master (output sw, irq_ack, input deb, change, irq);
  modport slave (input sw, irq_ack, output deb, change, irq);
endinterface

// File: rtl/veerwolf_sw_debounce_bit.sv
// veerwolf_debounce_bit: one switch bit, synchronizer plus tick-qualified stable counter
module veerwolf_debounce_bit #(
  parameter int   STABLE_TICKS = 20,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick_i,
  input  logic sw_i,
  output logic sw_o,
  output logic change_o
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic          s1_q, s2_q, sw_q, sw_d, chg_q, chg_d, diff, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  // any cycle where the level matches the output restarts qualification
  always_comb begin
    diff   = s2_q != sw_q;
    accept = diff && tick_i && cnt_q == LAST;
    cnt_d  = (!diff || accept) ? '0 : cnt_q + CW'(tick_i);
    sw_d   = accept ? s2_q : sw_q;
    chg_d  = accept;
  end
  // synchronizer, counter and output flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q  <= RESET_VAL;
      s2_q  <= RESET_VAL;
      sw_q  <= RESET_VAL;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= sw_i;
      s2_q  <= s1_q;
      sw_q  <= sw_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end
  assign sw_o     = sw_q;
  assign change_o = chg_q;
endmodule

// File: rtl/veerwolf_sw_debounce.sv
// veerwolf_sw_debounce: debounces WIDTH board switches and raises a sticky change interrupt
module veerwolf_sw_debounce #(
  parameter int               WIDTH        = 16,
  parameter int               TICK_DIV     = 50000,
  parameter int               STABLE_TICKS = 20,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_change,
  output logic             o_irq,
  input  logic             i_irq_ack
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick, irq_q, irq_d;
  // shared prescaler; a new change event takes priority over an acknowledge
  always_comb begin
    tick  = pre_q == PW'(TICK_DIV - 1);
    pre_d = tick ? '0 : pre_q + PW'(1);
    irq_d = |o_change ? 1'b1 : (i_irq_ack ? 1'b0 : irq_q);
  end
  // prescaler and interrupt flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q <= '0;
      irq_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      irq_q <= irq_d;
    end
  end
  assign o_irq = irq_q;
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    veerwolf_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_VAL   (RESET_VAL[g])
    ) u_bit (
      .clk     (clk),
      .rstn    (rstn),
      .tick_i  (tick),
      .sw_i    (i_sw[g]),
      .sw_o    (o_sw[g]),
      .change_o(o_change[g])
    );
  end
endmodule

// File: tb/tb_veerwolf_sw_debounce.sv
// tb_veerwolf_sw_debounce: directed scoreboard bench for the switch debouncer
module tb_veerwolf_sw_debounce;
  localparam int W = 16, TD = 4, ST = 3;
  logic clk = 1'b0;
  logic rstn;
  int n_vec = 0, n_err = 0, l;
  logic [31:0] sb[$];
  logic [31:0] e;
  always #5 clk = ~clk;
  veerwolf_sw_debounce_if #(.WIDTH(W)) sif ();
  veerwolf_sw_debounce #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .rstn(rstn), .i_sw(sif.sw), .o_sw(sif.deb),
    .o_change(sif.change), .o_irq(sif.irq), .i_irq_ack(sif.irq_ack)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic lat(input int b, output int lo);
    int k = 0;
    lo = -1;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (sif.deb[b]) begin
        lo = k - 1;
        break;
      end
    end
  endtask
  task automatic chk_lat(input string tag, input int lv);
    n_vec++;
    assert (lv >= 2 + (ST - 1) * TD && lv <= 1 + ST * TD) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, lv, 2 + (ST - 1) * TD, 1 + ST * TD);
    end
  endtask
  task automatic wait_change();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|sif.change) break;
    end
  endtask
  // every change pulse must match the next expected {o_change, o_sw} in the scoreboard
  always @(negedge clk) begin
    if (rstn && |sif.change) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=%h expected=none", {sif.change, sif.deb});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        assert ({sif.change, sif.deb} === e) else begin
          n_err++;
          $error("FAIL sb_event observed=%h expected=%h", {sif.change, sif.deb}, e);
        end
      end
    end
  end
  initial begin
    rstn = 1'b0;
    sif.sw = '0;
    sif.irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {sif.irq, sif.change, sif.deb}, 64'h0);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle", {sif.irq, sif.change, sif.deb}, 64'h0);
    end
    sb.push_back({16'h0008, 16'h0008});
    sif.sw = 16'h0008;
    lat(3, l);
    chk_lat("lat_bit3", l);
    chk("chg_bit3", sif.change, 16'h0008);
    @(negedge clk);
    chk("irq_set", sif.irq, 1);
    chk("chg_bit3_once", sif.change, 0);
    sif.irq_ack = 1'b1;
    @(negedge clk);
    sif.irq_ack = 1'b0;
    chk("irq_ack", sif.irq, 0);
    sb.push_back({16'h0008, 16'h0000});
    sif.sw = 16'h0000;
    repeat (20) @(negedge clk);
    chk("bit3_back", sif.deb, 0);
    sif.irq_ack = 1'b1;
    @(negedge clk);
    sif.irq_ack = 1'b0;
    chk("irq_ack2", sif.irq, 0);
    sif.irq_ack = 1'b1;
    @(negedge clk);
    sif.irq_ack = 1'b0;
    chk("ack_while_low", sif.irq, 0);
    sif.sw = 16'h0020;
    repeat (5) @(negedge clk);
    sif.sw = 16'h0000;
    repeat (30) @(negedge clk);
    chk("glitch_osw", sif.deb, 0);
    chk("glitch_irq", sif.irq, 0);
    sb.push_back({16'hFFFF, 16'hFFFF});
    sif.sw = 16'hFFFF;
    wait_change();
    chk("all_chg", sif.change, 16'hFFFF);
    chk("all_osw", sif.deb, 16'hFFFF);
    @(negedge clk);
    chk("all_chg_once", sif.change, 0);
    sb.push_back({16'hFFFF, 16'h0000});
    sif.sw = 16'h0000;
    wait_change();
    chk("fall_chg", sif.change, 16'hFFFF);
    sif.irq_ack = 1'b1;
    @(negedge clk);
    sif.irq_ack = 1'b0;
    chk("ack_coincide", sif.irq, 1);
    sif.irq_ack = 1'b1;
    @(negedge clk);
    sif.irq_ack = 1'b0;
    chk("ack_later", sif.irq, 0);
    sif.sw = 16'h0001;
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst", {sif.irq, sif.change, sif.deb}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    sb.push_back({16'h0001, 16'h0001});
    lat(0, l);
    chk_lat("lat_after_rst", l);
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
